// File: rtl/inbuf_pingpong_cntl.sv
// Ping/pong input line buffer: prefetches lines and presents each for M uses.
// INBUF_PINGPONG_PREFETCH_EN enables the second bank; otherwise one bank refills.
module inbuf_pingpong_cntl #(
    parameter int PACKET_LENGTH = 8,
    parameter int W             = 8,
    parameter int UNIT_NUM      = 4,
    parameter int DATA_W        = PACKET_LENGTH * W * UNIT_NUM,
    parameter int ADDR_W        = 10,
    parameter int M_W           = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              eng_rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_line_cnt,
    input  logic [M_W-1:0]    cfg_m,
    input  logic              eng_data_used,
    output logic [DATA_W-1:0] dout,
    output logic              dout_val,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_data_val
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, lines_q, lines_d;
    logic [ADDR_W-1:0] req_cnt_q, req_cnt_d, cons_q, cons_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [M_W-1:0]    m_q, m_d, use_q, use_d;
    logic [DATA_W-1:0] bank_q [2];
    logic [DATA_W-1:0] bank_d [2];
    logic [1:0]        val_q, val_d;
    logic              ptr_q, ptr_d, tgt_q, tgt_d;
    logic              out_q, out_d, drop_q, drop_d;
    logic              req_q, req_d, unf_q, unf_d;
    logic              done_q, busy_q;
    logic              use_ok, last_use, fetch_tgt;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        lines_d   = lines_q;
        m_d       = m_q;
        req_cnt_d = req_cnt_q;
        cons_d    = cons_q;
        use_d     = use_q;
        bank_d    = bank_q;
        val_d     = val_q;
        ptr_d     = ptr_q;
        tgt_d     = tgt_q;
        out_d     = out_q;
        drop_d    = drop_q;
        req_d     = 1'b0;
        addr_d    = addr_q;
        fetch_tgt = 1'b0;
        use_ok    = eng_data_used && val_q[ptr_q];
        last_use  = use_ok && (use_q == m_q - M_W'(1));
        unf_d     = unf_q || (eng_data_used && !val_q[ptr_q]);

        // A response owed to a request from before an engine reset is discarded.
        if (mem_rd_data_val) begin
            if (drop_q) begin
                drop_d = 1'b0;
            end else if (out_q) begin
                out_d         = 1'b0;
                bank_d[tgt_q] = mem_rd_data;
                val_d[tgt_q]  = 1'b1;
            end
        end

        if (use_ok) begin
            use_d = use_q + M_W'(1);
            if (last_use) begin
                use_d        = '0;
                val_d[ptr_q] = 1'b0;
                cons_d       = cons_q + ADDR_W'(1);
`ifdef INBUF_PINGPONG_PREFETCH_EN
                ptr_d        = ~ptr_q;
`endif
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unf_d     = 1'b0;
                    base_d    = cfg_base_addr;
                    lines_d   = cfg_line_cnt;
                    m_d       = (cfg_m == '0) ? M_W'(1) : cfg_m;
                    req_cnt_d = '0;
                    cons_d    = '0;
                    use_d     = '0;
                    state_d   = (cfg_line_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cons_d == lines_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Decide on next-state values so a freed bank refills with no lost cycle.
`ifdef INBUF_PINGPONG_PREFETCH_EN
        fetch_tgt = val_d[ptr_d] ? ~ptr_d : ptr_d;
`endif
        if (state_d == RUN && req_cnt_d < lines_d && !out_d
            && !val_d[fetch_tgt]) begin
            req_d     = 1'b1;
            out_d     = 1'b1;
            tgt_d     = fetch_tgt;
            addr_d    = base_d + req_cnt_d;
            req_cnt_d = req_cnt_d + ADDR_W'(1);
        end

        if (!eng_rstn) begin
            state_d   = IDLE;
            base_d    = '0;
            lines_d   = '0;
            m_d       = '0;
            req_cnt_d = '0;
            cons_d    = '0;
            use_d     = '0;
            bank_d[0] = '0;
            bank_d[1] = '0;
            val_d     = '0;
            ptr_d     = 1'b0;
            tgt_d     = 1'b0;
            out_d     = 1'b0;
            drop_d    = (out_q || drop_q) && !mem_rd_data_val;
            req_d     = 1'b0;
            addr_d    = '0;
            unf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            lines_q   <= '0;
            m_q       <= '0;
            req_cnt_q <= '0;
            cons_q    <= '0;
            use_q     <= '0;
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            val_q     <= '0;
            ptr_q     <= 1'b0;
            tgt_q     <= 1'b0;
            out_q     <= 1'b0;
            drop_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            unf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            lines_q   <= lines_d;
            m_q       <= m_d;
            req_cnt_q <= req_cnt_d;
            cons_q    <= cons_d;
            use_q     <= use_d;
            bank_q    <= bank_d;
            val_q     <= val_d;
            ptr_q     <= ptr_d;
            tgt_q     <= tgt_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            unf_q     <= unf_d;
            done_q    <= (state_d == DONE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign dout        = bank_q[ptr_q];
    assign dout_val    = val_q[ptr_q];
    assign busy        = busy_q;
    assign done        = done_q;
    assign underflow   = unf_q;
    assign mem_rd_req  = req_q;
    assign mem_rd_addr = addr_q;

endmodule
